// File: rtl/divisor_frec_multi.sv
// Multi-channel programmable square-wave / tick generator with glitch-free runtime top reload.
// Optional macro DIVFREQ_PHASE_ALIGN_EN adds a `sync` input that phase-aligns every channel.
module divisor_frec_multi #(
    parameter int CH          = 2,
    parameter int W           = 16,
    parameter int DEFAULT_TOP = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef DIVFREQ_PHASE_ALIGN_EN
    input  logic                 sync,
`endif
    input  logic [CH-1:0]        enable,
    input  logic                 wr_en,
    input  logic [$clog2(CH):0]  wr_ch,
    input  logic [W-1:0]         wr_top,
    output logic                 wr_ack,
    output logic [CH-1:0]        clkout,
    output logic [CH-1:0]        tick
);

    localparam int          CW      = $clog2(CH) + 1;
    localparam logic [W-1:0] TOP_RST = W'(DEFAULT_TOP);

    logic [CH-1:0][W-1:0] count_q,   count_d;
    logic [CH-1:0][W-1:0] active_q,  active_d;
    logic [CH-1:0][W-1:0] pending_q, pending_d;
    logic [CH-1:0]        clkout_q,  clkout_d;
    logic [CH-1:0]        tick_q,    tick_d;
    logic                 wr_ack_q,  wr_ack_d;
    logic [CH-1:0]        wr_hit_s;

    // Write address decode; an out-of-range channel index matches nothing and is dropped.
    always_comb begin
        wr_hit_s = {CH{1'b0}};
        for (int i = 0; i < CH; i++) begin
            if (wr_en && (wr_ch == CW'(i))) begin
                wr_hit_s[i] = 1'b1;
            end else begin
                wr_hit_s[i] = 1'b0;
            end
        end
    end

    // Next-state computation for every channel and the write acknowledge.
    always_comb begin
        count_d   = count_q;
        active_d  = active_q;
        pending_d = pending_q;
        clkout_d  = clkout_q;
        tick_d    = {CH{1'b0}};
        wr_ack_d  = wr_en;
        for (int i = 0; i < CH; i++) begin
`ifdef DIVFREQ_PHASE_ALIGN_EN
            if (sync) begin
                count_d[i]  = {W{1'b0}};
                clkout_d[i] = 1'b0;
                active_d[i] = pending_q[i];
                if (wr_hit_s[i]) begin
                    pending_d[i] = wr_top;
                end else begin
                    pending_d[i] = pending_q[i];
                end
            end else begin
`endif
                if (enable[i]) begin
                    // Terminal count reloads active from the pending value seen before this edge.
                    if (count_q[i] == active_q[i]) begin
                        count_d[i]  = {W{1'b0}};
                        clkout_d[i] = ~clkout_q[i];
                        tick_d[i]   = 1'b1;
                        active_d[i] = pending_q[i];
                    end else begin
                        count_d[i]  = count_q[i] + W'(1);
                    end
                end else begin
                    count_d[i] = count_q[i];
                end
                if (wr_hit_s[i]) begin
                    pending_d[i] = wr_top;
                    // A stopped channel takes the new top at once and restarts cleanly.
                    if (!enable[i]) begin
                        active_d[i] = wr_top;
                        count_d[i]  = {W{1'b0}};
                    end else begin
                        active_d[i] = active_d[i];
                    end
                end else begin
                    pending_d[i] = pending_d[i];
                end
`ifdef DIVFREQ_PHASE_ALIGN_EN
            end
`endif
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= {CH{{W{1'b0}}}};
            active_q  <= {CH{TOP_RST}};
            pending_q <= {CH{TOP_RST}};
            clkout_q  <= {CH{1'b0}};
            tick_q    <= {CH{1'b0}};
            wr_ack_q  <= 1'b0;
        end else begin
            count_q   <= count_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            clkout_q  <= clkout_d;
            tick_q    <= tick_d;
            wr_ack_q  <= wr_ack_d;
        end
    end

    assign clkout = clkout_q;
    assign tick   = tick_q;
    assign wr_ack = wr_ack_q;

endmodule

// File: tb/tb_divisor_frec_multi.sv
// Table-driven, scoreboarded bench for divisor_frec_multi (CH=2, DEFAULT_TOP=3).
module tb_divisor_frec_multi;

    localparam int CH = 2;
    localparam int W  = 16;
    localparam int CW = $clog2(CH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
`ifdef DIVFREQ_PHASE_ALIGN_EN
    logic          sync;
`endif
    logic [CH-1:0] enable;
    logic          wr_en;
    logic [CW-1:0] wr_ch;
    logic [W-1:0]  wr_top;
    logic          wr_ack;
    logic [CH-1:0] clkout;
    logic [CH-1:0] tick;

    always #5 clk = ~clk;

    divisor_frec_multi #(.CH(CH), .W(W), .DEFAULT_TOP(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef DIVFREQ_PHASE_ALIGN_EN
        .sync   (sync),
`endif
        .enable (enable),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_top (wr_top),
        .wr_ack (wr_ack),
        .clkout (clkout),
        .tick   (tick)
    );

    typedef struct {
        logic          rst_n;
`ifdef DIVFREQ_PHASE_ALIGN_EN
        logic          sync;
`endif
        logic [CH-1:0] en;
        logic          we;
        logic [CW-1:0] ch;
        logic [W-1:0]  top;
        logic [CH-1:0] exp_clk;
        logic [CH-1:0] exp_tick;
        logic          exp_ack;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic r, input logic [CH-1:0] en, input logic we,
                                input logic [CW-1:0] ch, input logic [W-1:0] top,
                                input logic [CH-1:0] ec, input logic [CH-1:0] et, input logic ea);
        vec_t v;
        v.rst_n = r;
`ifdef DIVFREQ_PHASE_ALIGN_EN
        v.sync = 1'b0;
`endif
        v.en = en; v.we = we; v.ch = ch; v.top = top;
        v.exp_clk = ec; v.exp_tick = et; v.exp_ack = ea;
        return v;
    endfunction

    // Plain running cycle (no write).
    task automatic st(input logic [CH-1:0] en, input logic [CH-1:0] ec, input logic [CH-1:0] et);
        vecs.push_back(mk(1'b1, en, 1'b0, 2'd0, 16'd0, ec, et, 1'b0));
    endtask

    // Cycle with a write.
    task automatic wr(input logic [CH-1:0] en, input logic [CW-1:0] ch, input logic [W-1:0] top,
                      input logic [CH-1:0] ec, input logic [CH-1:0] et);
        vecs.push_back(mk(1'b1, en, 1'b1, ch, top, ec, et, 1'b1));
    endtask

    task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp, input int idx);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        vec_t e;
        // reset
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 2'd0, 16'd0, 2'b00, 2'b00, 1'b0));
        // T1: default top 3, ch1 disabled
        for (int k = 0; k < 3; k++) st(2'b01, 2'b00, 2'b00);
        st(2'b01, 2'b01, 2'b01);
        for (int k = 0; k < 3; k++) st(2'b01, 2'b01, 2'b00);
        st(2'b01, 2'b00, 2'b01);
        // T3: write top=1 at count=1; current half-period still 4 cycles
        st(2'b01, 2'b00, 2'b00);
        wr(2'b01, 2'd0, 16'd1, 2'b00, 2'b00);
        st(2'b01, 2'b00, 2'b00);
        st(2'b01, 2'b01, 2'b01);
        st(2'b01, 2'b01, 2'b00);
        st(2'b01, 2'b00, 2'b01);
        st(2'b01, 2'b00, 2'b00);
        st(2'b01, 2'b01, 2'b01);
        // T4: back to top=3, hold at count=2, dropped write to channel CH
        wr(2'b01, 2'd0, 16'd3, 2'b01, 2'b00);
        st(2'b01, 2'b00, 2'b01);
        st(2'b01, 2'b00, 2'b00);
        st(2'b01, 2'b00, 2'b00);
        st(2'b00, 2'b00, 2'b00);
        wr(2'b00, 2'd2, 16'd5, 2'b00, 2'b00);
        for (int k = 0; k < 3; k++) st(2'b00, 2'b00, 2'b00);
        st(2'b01, 2'b00, 2'b00);
        st(2'b01, 2'b01, 2'b01);
        // T5: write top=7 on the terminal edge
        for (int k = 0; k < 3; k++) st(2'b01, 2'b01, 2'b00);
        wr(2'b01, 2'd0, 16'd7, 2'b00, 2'b01);
        for (int k = 0; k < 3; k++) st(2'b01, 2'b00, 2'b00);
        st(2'b01, 2'b01, 2'b01);
        for (int k = 0; k < 7; k++) st(2'b01, 2'b01, 2'b00);
        st(2'b01, 2'b00, 2'b01);
        st(2'b01, 2'b00, 2'b00);
        // reset mid-count, top returns to 3
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 2'd0, 16'd0, 2'b00, 2'b00, 1'b0));
        for (int k = 0; k < 3; k++) st(2'b01, 2'b00, 2'b00);
        st(2'b01, 2'b01, 2'b01);
        // T2: top=0 written while disabled -> toggle every edge
        wr(2'b00, 2'd0, 16'd0, 2'b01, 2'b00);
        st(2'b01, 2'b00, 2'b01);
        st(2'b01, 2'b01, 2'b01);
        st(2'b01, 2'b00, 2'b01);
        st(2'b01, 2'b01, 2'b01);
        // both channels running, ch1 on default top 3
        st(2'b11, 2'b00, 2'b01);
        st(2'b11, 2'b01, 2'b01);
        st(2'b11, 2'b00, 2'b01);
        st(2'b11, 2'b11, 2'b11);
`ifdef DIVFREQ_PHASE_ALIGN_EN
        // T6: ch0 top=1, ch1 top=4, free run then sync
        wr(2'b00, 2'd0, 16'd1, 2'b11, 2'b00);
        wr(2'b00, 2'd1, 16'd4, 2'b11, 2'b00);
        st(2'b11, 2'b11, 2'b00);
        st(2'b11, 2'b10, 2'b01);
        st(2'b11, 2'b10, 2'b00);
        v = mk(1'b1, 2'b11, 1'b0, 2'd0, 16'd0, 2'b00, 2'b00, 1'b0);
        v.sync = 1'b1;
        vecs.push_back(v);
        st(2'b11, 2'b00, 2'b00);
        st(2'b11, 2'b01, 2'b01);
        st(2'b11, 2'b01, 2'b00);
        st(2'b11, 2'b00, 2'b01);
        st(2'b11, 2'b10, 2'b10);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            rst_n  = v.rst_n;
`ifdef DIVFREQ_PHASE_ALIGN_EN
            sync   = v.sync;
`endif
            enable = v.en;
            wr_en  = v.we;
            wr_ch  = v.ch;
            wr_top = v.top;
            sb.push_back(v);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check("clkout", clkout, e.exp_clk, i);
            check("tick", tick, e.exp_tick, i);
            check("wr_ack", {{(CH-1){1'b0}}, wr_ack}, {{(CH-1){1'b0}}, e.exp_ack}, i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
